// File: rtl/snn_pkg.sv
// Shared definitions for the reward evaluator: reward encodings, FSM state
// type, counter width and a saturating-increment helper.
package snn_pkg;

    // Width of the saturating accuracy counters.
    localparam int unsigned SAT_W = 8;

    // Width of network scores and targets.
    localparam int unsigned SCORE_W = 8;

    // Reward token encodings.
    localparam logic [1:0] REWARD_POS  = 2'b01;
    localparam logic [1:0] REWARD_NEG  = 2'b11;
    localparam logic [1:0] REWARD_NONE = 2'b00;

    // Evaluator FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EVAL  = 2'd2,
        ST_ISSUE = 2'd3
    } eval_state_t;

    // Increment by one when en is set, holding at all-ones instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != {SAT_W{1'b1}})) begin
            return v + SAT_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/reward_evaluator_if.sv
// Handshake bundle of the reward evaluator.
//   target / target_valid / target_ready : per-trial target, accepted in IDLE
//   prediction / pred_valid              : network score stream
//   reward / reward_valid / reward_ready : signed reward token to learning logic
// slave is the evaluator side, master is the environment side.
interface reward_evaluator_if;
    import snn_pkg::*;

    logic [SCORE_W-1:0] target;
    logic               target_valid;
    logic               target_ready;
    logic [SCORE_W-1:0] prediction;
    logic               pred_valid;
    logic               reward_valid;
    logic               reward_ready;
    logic [1:0]         reward;

    modport slave (
        input  target, target_valid, prediction, pred_valid, reward_ready,
        output target_ready, reward_valid, reward
    );

    modport master (
        output target, target_valid, prediction, pred_valid, reward_ready,
        input  target_ready, reward_valid, reward
    );

endinterface

// File: rtl/pred_window_acc.sv
// Window accumulator: sums accepted predictions and counts samples.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : zero the sum and sample count (new trial)
//   pred_valid  : add prediction this cycle
//   prediction  : 8-bit score
//   acc         : running sum, wide enough that a full window cannot overflow
//   last_sample : next accepted sample completes the window
module pred_window_acc
    import snn_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           pred_valid,
    input  logic [SCORE_W-1:0]             prediction,
    output logic [SCORE_W+WINDOW_LOG2-1:0] acc,
    output logic                           last_sample
);

    localparam int unsigned ACC_W = SCORE_W + WINDOW_LOG2;
    localparam int unsigned CNT_W = WINDOW_LOG2;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    // Next sum/count; the count wraps to zero as the window completes.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (pred_valid) begin
            acc_d = acc_q + ACC_W'(prediction);
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Registered flag equal to (count == window-1).
        last_d = &cnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign acc         = acc_q;
    assign last_sample = last_q;

endmodule

// File: rtl/reward_evaluator.sv
// Averages a window of network predictions, compares the average to a
// per-trial target and issues a +1/-1/none reward token; keeps saturating
// hit and trial counters.
//   clk, rst    : clock, synchronous active-high reset
//   write_mode  : 1 learning (reward issued), 0 inference (reward none)
//   bus         : target / prediction / reward handshakes (slave side)
//   avg_pred    : last computed window average
//   hit_count   : saturating hit counter
//   trial_count : saturating evaluated-trial counter
//   busy        : high whenever a trial is in progress
module reward_evaluator
    import snn_pkg::*;
#(
    parameter int unsigned        WINDOW_LOG2 = 2,
    parameter logic [SCORE_W-1:0] TOL         = 8'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_mode,
    reward_evaluator_if.slave      bus,
    output logic [SCORE_W-1:0]     avg_pred,
    output logic [SAT_W-1:0]       hit_count,
    output logic [SAT_W-1:0]       trial_count,
    output logic                   busy
);

    localparam int unsigned ACC_W = SCORE_W + WINDOW_LOG2;

    eval_state_t        state_q, state_d;
    logic [SCORE_W-1:0] tgt_q, tgt_d;
    logic [SCORE_W-1:0] avg_q, avg_d;
    logic [1:0]         reward_q, reward_d;
    logic               rv_q, rv_d;
    logic [SAT_W-1:0]   hit_q, hit_d;
    logic [SAT_W-1:0]   trial_q, trial_d;
    logic               tr_q, tr_d;
    logic               busy_q, busy_d;

    logic               acc_clear;
    logic               acc_en;
    logic [ACC_W-1:0]   acc;
    logic               last_sample;

    logic [SCORE_W-1:0] avg_c;
    logic signed [8:0]  diff_c;
    logic [8:0]         abs_diff_c;
    logic               hit_c;

    pred_window_acc #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (acc_clear),
        .pred_valid  (acc_en),
        .prediction  (bus.prediction),
        .acc         (acc),
        .last_sample (last_sample)
    );

    // Truncating average and absolute distance to the latched target.
    always_comb begin
        avg_c      = acc[WINDOW_LOG2 +: SCORE_W];
        diff_c     = $signed({1'b0, avg_c}) - $signed({1'b0, tgt_q});
        abs_diff_c = diff_c[8] ? 9'(-diff_c) : 9'(diff_c);
        hit_c      = (abs_diff_c <= 9'(TOL));
    end

    // Next-state and next-register values.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        avg_d     = avg_q;
        reward_d  = reward_q;
        rv_d      = rv_q;
        hit_d     = hit_q;
        trial_d   = trial_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.target_valid && tr_q) begin
                    tgt_d     = bus.target;
                    acc_clear = 1'b1;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.pred_valid) begin
                    acc_en = 1'b1;
                    if (last_sample) begin
                        state_d = ST_EVAL;
                    end
                end
            end
            ST_EVAL: begin
                avg_d    = avg_c;
                reward_d = write_mode ? (hit_c ? REWARD_POS : REWARD_NEG) : REWARD_NONE;
                trial_d  = sat_inc(trial_q, 1'b1);
                hit_d    = sat_inc(hit_q, hit_c);
                rv_d     = 1'b1;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (rv_q && bus.reward_ready) begin
                    rv_d     = 1'b0;
                    reward_d = REWARD_NONE;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs registered from the next state so they line up with it.
        tr_d   = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q    <= '0;
            avg_q    <= '0;
            reward_q <= REWARD_NONE;
            rv_q     <= 1'b0;
            hit_q    <= '0;
            trial_q  <= '0;
            tr_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            tgt_q    <= tgt_d;
            avg_q    <= avg_d;
            reward_q <= reward_d;
            rv_q     <= rv_d;
            hit_q    <= hit_d;
            trial_q  <= trial_d;
            tr_q     <= tr_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.target_ready = tr_q;
    assign bus.reward_valid = rv_q;
    assign bus.reward       = reward_q;
    assign avg_pred         = avg_q;
    assign hit_count        = hit_q;
    assign trial_count      = trial_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_reward_evaluator.sv
// Directed bench for reward_evaluator with a token scoreboard.
module tb_reward_evaluator;
    import snn_pkg::*;

    logic       clk;
    logic       rst;
    logic       write_mode;
    logic [7:0] avg_pred;
    logic [7:0] hit_count;
    logic [7:0] trial_count;
    logic       busy;

    reward_evaluator_if bus ();

    reward_evaluator dut (
        .clk         (clk),
        .rst         (rst),
        .write_mode  (write_mode),
        .bus         (bus),
        .avg_pred    (avg_pred),
        .hit_count   (hit_count),
        .trial_count (trial_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] reward;
        logic [7:0] avg;
    } tok_t;

    tok_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_hits   = 0;
    int   exp_trials = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every token handshake is compared against the scoreboard.
    initial begin
        tok_t e;
        forever begin
            @(negedge clk);
            if (bus.reward_valid && bus.reward_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_token", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("token_reward", int'(bus.reward), int'(e.reward));
                    check("token_avg", int'(avg_pred), int'(e.avg));
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.target_valid = 1'b0;
        bus.pred_valid   = 1'b0;
        bus.prediction   = 8'd0;
        bus.reward_ready = 1'b0;
    endtask

    // Offer a target and wait (bounded) for it to be accepted.
    task automatic send_target(input logic [7:0] t, input bit junk);
        int waited = 0;
        if (junk) begin
            // Predictions offered in IDLE must be dropped.
            for (int k = 0; k < 2; k++) begin
                @(posedge clk); #1;
                bus.pred_valid = 1'b1;
                bus.prediction = 8'd255;
            end
            @(posedge clk); #1;
            bus.pred_valid = 1'b0;
        end
        @(negedge clk);
        while (!bus.target_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.target_ready) check("target_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.target       = t;
        bus.target_valid = 1'b1;
        @(posedge clk); #1;
        bus.target_valid = 1'b0;
    endtask

    // One full trial; expected reward/avg are hand-computed by the caller.
    task automatic run_trial(input logic [7:0] t,
                             input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3,
                             input logic wm, input int hold, input bit junk,
                             input logic [1:0] exp_rew, input logic [7:0] exp_avg,
                             input bit exp_hit);
        logic [7:0] p[4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        write_mode = wm;
        exp_q.push_back('{reward: exp_rew, avg: exp_avg});
        send_target(t, junk);
        for (int i = 0; i < 4; i++) begin
            bus.prediction = p[i];
            bus.pred_valid = 1'b1;
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        // Last sample presented in cycle N.
        @(posedge clk); #1;
        bus.pred_valid = 1'b0;
        @(negedge clk);
        check("latency_n1_low", int'(bus.reward_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("latency_n2_high", int'(bus.reward_valid), 1);
        check("issue_target_ready", int'(bus.target_ready), 0);
        if (exp_trials < 255) exp_trials++;
        if (exp_hit && exp_hits < 255) exp_hits++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (junk) begin
                bus.pred_valid = 1'b1;
                bus.prediction = 8'd255;
            end
            @(negedge clk);
            check("hold_valid", int'(bus.reward_valid), 1);
            check("hold_reward", int'(bus.reward), int'(exp_rew));
            check("hold_avg", int'(avg_pred), int'(exp_avg));
            check("hold_target_ready", int'(bus.target_ready), 0);
        end
        @(posedge clk); #1;
        bus.pred_valid   = 1'b0;
        bus.reward_ready = 1'b1;
        @(posedge clk); #1;
        bus.reward_ready = 1'b0;
        @(negedge clk);
        check("post_valid", int'(bus.reward_valid), 0);
        check("post_reward", int'(bus.reward), 0);
        check("post_target_ready", int'(bus.target_ready), 1);
        check("post_busy", int'(busy), 0);
        check("hit_count", int'(hit_count), exp_hits);
        check("trial_count", int'(trial_count), exp_trials);
    endtask

    initial begin
        rst        = 1'b1;
        write_mode = 1'b1;
        bus.target = 8'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_target_ready", int'(bus.target_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(bus.reward_valid), 0);
        check("rst_reward", int'(bus.reward), 0);
        check("rst_avg", int'(avg_pred), 0);
        check("rst_hits", int'(hit_count), 0);
        check("rst_trials", int'(trial_count), 0);

        // Hit in learning mode: sum 404, avg 101.
        run_trial(8'd100, 8'd98, 8'd102, 8'd100, 8'd104, 1'b1, 0, 1'b0, REWARD_POS, 8'd101, 1'b1);
        // Miss.
        run_trial(8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 0, 1'b0, REWARD_NEG, 8'd0, 1'b0);
        // Tolerance edge: diff 4 hits, diff 5 misses.
        run_trial(8'd100, 8'd104, 8'd104, 8'd104, 8'd104, 1'b1, 0, 1'b0, REWARD_POS, 8'd104, 1'b1);
        run_trial(8'd100, 8'd105, 8'd105, 8'd105, 8'd105, 1'b1, 0, 1'b0, REWARD_NEG, 8'd105, 1'b0);
        // Truncation: 403 >> 2 = 100.
        run_trial(8'd100, 8'd100, 8'd100, 8'd100, 8'd103, 1'b1, 0, 1'b0, REWARD_POS, 8'd100, 1'b1);
        // Inference with backpressure.
        run_trial(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 5, 1'b0, REWARD_NONE, 8'd100, 1'b1);
        // Dropped predictions in IDLE and ISSUE: sums 200 and 806.
        run_trial(8'd50, 8'd50, 8'd52, 8'd48, 8'd50, 1'b1, 3, 1'b1, REWARD_POS, 8'd50, 1'b1);
        run_trial(8'd200, 8'd200, 8'd201, 8'd202, 8'd203, 1'b1, 0, 1'b1, REWARD_POS, 8'd201, 1'b1);

        // Reset after two samples of a trial.
        write_mode = 1'b1;
        send_target(8'd10, 1'b0);
        bus.prediction = 8'd250;
        bus.pred_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.pred_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_target_ready", int'(bus.target_ready), 1);
        check("midrst_valid", int'(bus.reward_valid), 0);
        check("midrst_hits", int'(hit_count), 0);
        check("midrst_trials", int'(trial_count), 0);
        check("midrst_avg", int'(avg_pred), 0);
        exp_hits   = 0;
        exp_trials = 0;
        run_trial(8'd10, 8'd12, 8'd12, 8'd12, 8'd12, 1'b1, 0, 1'b0, REWARD_POS, 8'd12, 1'b1);

        // Saturation of both counters.
        for (int n = 0; n < 260; n++) begin
            run_trial(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 1'b1, 0, 1'b0, REWARD_POS, 8'd100, 1'b1);
        end
        check("sat_hits", int'(hit_count), 255);
        check("sat_trials", int'(trial_count), 255);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
